// File: rtl/pmux_arb.sv
// Registered N-way valid/ready arbiter: fixed-priority or round-robin winner
// selection feeding a single-entry output register with a valid/ready handshake.
module pmux_arb #(
   parameter int N  = 8,
   parameter int W  = 16,
   parameter bit RR = 1'b1,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N-1:0]     valid_i,
   input  logic [N*W-1:0]   data_i,
   output logic [N-1:0]     ready_o,
   output logic [W-1:0]     q_o,
   output logic [SEL_W-1:0] sel_o,
   output logic             q_valid_o,
   input  logic             q_ready_i
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] scan_base;
   logic [SEL_W-1:0] win;
   logic [W-1:0]     win_data;
   logic             found;
   logic             load_en;
   logic             take;

   assign load_en   = !q_valid_o || q_ready_i;
   assign scan_base = RR ? ptr : '0;

   // Scan from scan_base upward with explicit wrap, so non-power-of-two N works.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < N; i++) begin
         int j;
         j = int'(scan_base) + i;
         if (j >= N) j = j - N;
         if (!found && valid_i[j]) begin
            found = 1'b1;
            win   = SEL_W'(j);
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int k = 0; k < N; k++) begin
         if (win == SEL_W'(k)) win_data = data_i[k*W +: W];
      end
   end

   assign take = load_en && found && !rst_i;

   always_comb begin
      ready_o = '0;
      for (int k = 0; k < N; k++) begin
         ready_o[k] = take && (win == SEL_W'(k));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_o       <= '0;
         sel_o     <= '0;
         q_valid_o <= 1'b0;
         ptr       <= '0;
      end else if (load_en) begin
         if (found) begin
            q_o       <= win_data;
            sel_o     <= win;
            q_valid_o <= 1'b1;
            if (int'(win) == N - 1) ptr <= '0;
            else                    ptr <= win + SEL_W'(1);
         end else begin
            q_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pmux_arb.sv
// Directed and seeded-random checks of pmux_arb in round-robin (N=8, N=5)
// and fixed-priority (N=8) configurations.
module tb_pmux_arb;

   logic clk = 1'b0;
   logic rst;

   logic [7:0]   va, ra;
   logic [127:0] da;
   logic [15:0]  qa;
   logic [2:0]   sa;
   logic         qva, qra;

   logic [7:0]   vb, rb;
   logic [127:0] db;
   logic [15:0]  qb;
   logic [2:0]   sb;
   logic         qvb, qrb;

   logic [4:0]   vc, rc;
   logic [79:0]  dc;
   logic [15:0]  qc;
   logic [2:0]   sc;
   logic         qvc, qrc;

   int n_checks = 0;
   int n_pass   = 0;

   pmux_arb #(.N(8), .W(16), .RR(1'b1)) dut_rr (
      .clk_i(clk), .rst_i(rst), .valid_i(va), .data_i(da), .ready_o(ra),
      .q_o(qa), .sel_o(sa), .q_valid_o(qva), .q_ready_i(qra));

   pmux_arb #(.N(8), .W(16), .RR(1'b0)) dut_fp (
      .clk_i(clk), .rst_i(rst), .valid_i(vb), .data_i(db), .ready_o(rb),
      .q_o(qb), .sel_o(sb), .q_valid_o(qvb), .q_ready_i(qrb));

   pmux_arb #(.N(5), .W(16), .RR(1'b1)) dut_n5 (
      .clk_i(clk), .rst_i(rst), .valid_i(vc), .data_i(dc), .ready_o(rc),
      .q_o(qc), .sel_o(sc), .q_valid_o(qvc), .q_ready_i(qrc));

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // reference model state for the N=5 random run
   logic [15:0] m_q;
   logic [2:0]  m_sel;
   logic        m_qv;
   int          m_ptr;

   initial begin
      rst = 1'b1;
      va = 8'hFF; qra = 1'b1;
      vb = 8'hA4; qrb = 1'b1;
      vc = 5'h1F; qrc = 1'b1;
      for (int k = 0; k < 8; k++) begin
         da[k*16 +: 16] = 16'hA000 + 16'(k);
         db[k*16 +: 16] = 16'hB000 + 16'(k);
      end
      for (int k = 0; k < 5; k++) dc[k*16 +: 16] = 16'hC000 + 16'(k);

      // reset held two cycles with every channel valid
      repeat (2) begin
         @(negedge clk);
         chk("rst_ready", 32'(ra), 32'h0);
         chk("rst_qv", 32'(qva), 32'h0);
         chk("rst_q", 32'(qa), 32'h0);
         chk("rst_sel", 32'(sa), 32'h0);
      end
      rst = 1'b0;
      #1 chk("first_grant", 32'(ra), 32'h01);

      // round-robin sweep, one beat per cycle
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("rr_sel", 32'(sa), 32'(i % 8));
         chk("rr_q", 32'(qa), 32'h0000A000 + 32'(i % 8));
         chk("rr_qv", 32'(qva), 32'h1);
      end

      // load ch3 with 1234, then backpressure
      va = 8'h08;
      da[3*16 +: 16] = 16'h1234;
      @(negedge clk);
      chk("bp_load_q", 32'(qa), 32'h1234);
      chk("bp_load_sel", 32'(sa), 32'h3);
      qra = 1'b0;
      va = 8'hFF;
      #1 chk("bp_ready", 32'(ra), 32'h0);
      repeat (4) begin
         @(negedge clk);
         chk("bp_hold_q", 32'(qa), 32'h1234);
         chk("bp_hold_sel", 32'(sa), 32'h3);
         chk("bp_hold_qv", 32'(qva), 32'h1);
         chk("bp_hold_ready", 32'(ra), 32'h0);
      end
      qra = 1'b1;
      #1 chk("bp_resume_ready", 32'(ra), 32'h10);
      @(negedge clk);
      chk("bp_resume_sel", 32'(sa), 32'h4);
      chk("bp_resume_q", 32'(qa), 32'hA004);

      // grant ch7, idle, then pointer must have wrapped to 0
      va = 8'h80;
      #1 chk("wrap_ready7", 32'(ra), 32'h80);
      @(negedge clk);
      chk("wrap_sel7", 32'(sa), 32'h7);
      va = 8'h00;
      repeat (3) begin
         @(negedge clk);
         chk("idle_qv", 32'(qva), 32'h0);
         chk("idle_sel_hold", 32'(sa), 32'h7);
      end
      va = 8'h82;
      #1 chk("wrap_ready1", 32'(ra), 32'h02);
      @(negedge clk);
      chk("wrap_sel1", 32'(sa), 32'h1);
      chk("wrap_q1", 32'(qa), 32'hA001);

      // reset in the middle of a held beat
      rst = 1'b1;
      va = 8'hFF;
      #1 chk("midrst_ready", 32'(ra), 32'h0);
      @(negedge clk);
      chk("midrst_qv", 32'(qva), 32'h0);
      chk("midrst_q", 32'(qa), 32'h0);
      rst = 1'b0;

      // fixed priority
      #1 chk("fp_ready", 32'(rb), 32'h04);
      repeat (3) begin
         @(negedge clk);
         chk("fp_sel2", 32'(sb), 32'h2);
         chk("fp_q2", 32'(qb), 32'hB002);
      end
      vb = 8'hA0;
      repeat (2) begin
         @(negedge clk);
         chk("fp_sel5", 32'(sb), 32'h5);
         chk("fp_q5", 32'(qb), 32'hB005);
      end

      // N=5 round-robin sweep
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("n5_sel", 32'(sc), 32'(i % 5));
         chk("n5_q", 32'(qc), 32'h0000C000 + 32'(i % 5));
      end

      // N=5 seeded random against a reference model
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_q = '0; m_sel = '0; m_qv = 1'b0; m_ptr = 0;
      void'($urandom(123));
      for (int cyc = 0; cyc < 1000; cyc++) begin
         int     win;
         logic [4:0] exp_ready;
         chk("rnd_qv", 32'(qvc), 32'(m_qv));
         if (m_qv) begin
            chk("rnd_q", 32'(qc), 32'(m_q));
            chk("rnd_sel", 32'(sc), 32'(m_sel));
         end
         vc  = 5'($urandom_range(0, 31));
         qrc = 1'($urandom_range(0, 1));
         for (int k = 0; k < 5; k++) dc[k*16 +: 16] = 16'($urandom);
         #1;
         win = -1;
         for (int i = 0; i < 5; i++) begin
            int j;
            j = (m_ptr + i) % 5;
            if (win < 0 && vc[j]) win = j;
         end
         exp_ready = '0;
         if ((!m_qv || qrc) && win >= 0) exp_ready[win] = 1'b1;
         chk("rnd_ready", 32'(rc), 32'(exp_ready));
         chk("rnd_onehot", 32'($countones(rc) <= 1), 32'h1);
         if (!m_qv || qrc) begin
            if (win >= 0) begin
               m_q   = dc[win*16 +: 16];
               m_sel = 3'(win);
               m_qv  = 1'b1;
               m_ptr = (win + 1) % 5;
            end else begin
               m_qv = 1'b0;
            end
         end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pmux_arb.md
# pmux_arb

Parametrised, registered successor to the combinational `pmux` select block. It arbitrates among `N` valid/ready input channels of `W` bits each, using either fixed-priority or round-robin selection. It forwards one winning beat per cycle into a single-entry output register with a valid/ready handshake. It sits between several producers and one consumer wherever the plain select-driven mux needs flow control and fairness.

## Interface
Parameters:
- `N`, 8, number of input channels (≥1).
- `W`, 16, data width per channel (≥1).
- `RR`, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- Localparam `SEL_W` = max(1, clog2(N)).

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  N  per-channel valid.
- `data_i`  in  N*W  flattened data; channel k occupies `[k*W +: W]`.
- `ready_o`  out  N  per-channel grant/ready (one-hot or zero).
- `q_o`  out  W  registered output data.
- `sel_o`  out  SEL_W  index of the channel that supplied `q_o`.
- `q_valid_o`  out  1  output register holds a beat.
- `q_ready_i`  in  1  consumer accepts `q_o` this cycle.

## Operation
- `load_en` = `!q_valid_o || q_ready_i`. The output register can take a new beat this cycle.
- Winner selection (combinational, only among channels with `valid_i` = 1):
  - `RR`=0: the lowest set index.
  - `RR`=1: the first set index scanning `ptr`, `ptr+1`, … `N-1`, 0, … `ptr-1`.
- `ready_o`:
  - Equals onehot(winner) when `load_en` is 1, at least one `valid_i` is set, and `rst_i` is 0.
  - Otherwise all zeros.
  - It never has more than one bit set.
- Handshake on channel k means `valid_i[k]` && `ready_o[k]`. On a handshake, at the next edge:
  - `q_o` ← `data_i[k*W +: W]`.
  - `sel_o` ← k.
  - `q_valid_o` ← 1.
  - `ptr` ← k+1, wrapping N-1 to 0. This also holds for non-power-of-two N.
- `load_en` with no valid input: `q_valid_o` ← 0. `q_o` and `sel_o` hold their previous values.
- `!load_en` (held beat not consumed): `q_o`, `sel_o`, `q_valid_o` and `ptr` hold, and `ready_o` is all zeros.
- `ptr` advances only on a handshake. An idle cycle or a withdrawn `valid_i` does not move it.
- In `RR`=0 mode `ptr` is unused and may be optimised away.
- Data on non-granted channels is ignored. A producer may deassert `valid_i` without a handshake.
- N=1: the block degenerates to a one-entry register slice, with `sel_o` always 0.

## Timing
- Reset values: `q_o` = 0, `sel_o` = 0, `q_valid_o` = 0, `ptr` = 0. `ready_o` = 0 for every cycle in which `rst_i` is high.
- Latency: a beat accepted at edge t is visible on `q_o` with `q_valid_o` = 1 in cycle t+1.
- Throughput: 1 beat/cycle while `q_ready_i` is held high. A drain and a new load in the same cycle is a required case (no bubble).
- `ready_o` depends combinationally on `valid_i`, `q_valid_o` and `q_ready_i`. Producers must not make `valid_i` depend on `ready_o`.
- Reset mid-operation: a beat held in the register is discarded, and no handshake occurs during the reset cycle.
- Simultaneous events:
  - Drain plus new valid: load the new winner.
  - Drain with no valid: `q_valid_o` falls.
  - Multiple valids: exactly one grant per cycle.
- Fairness (`RR`=1): with all N channels continuously valid and the output always ready, each channel is granted exactly once in every N consecutive beats.

## Test plan
- Reset: assert `rst_i` for 2 cycles with all `valid_i` = 1. Required: `ready_o` = 0, `q_valid_o` = 0, `q_o` = 0, `sel_o` = 0. First grant after release goes to ch0.
- Round-robin (N=8, W=16, RR=1): `valid_i` = 8'hFF, `q_ready_i` = 1, `data_i` ch k = 16'hA000+k.
  - Required `sel_o` sequence: 0,1,…,7,0.
  - Required `q_o` sequence: A000…A007, A000.
  - One beat per cycle, no bubbles.
- Fixed priority (RR=0): `valid_i` = 8'b1010_0100. Required: `sel_o` = 2 every cycle.
  - Then `valid_i` = 8'b1010_0000 → `sel_o` = 5.
- Backpressure: after one beat is loaded from ch3 (`q_o` = 16'h1234), drop `q_ready_i` for 4 cycles while `valid_i` = 8'hFF.
  - Required: `q_o` = 16'h1234, `sel_o` = 3 and `q_valid_o` = 1 held; `ready_o` = 0; `ptr` unchanged.
  - On raising `q_ready_i`: the next beat comes from ch4.
- Pointer wrap and idle: RR mode, last grant ch7, then 3 idle cycles, then `valid_i` = 8'b1000_0010. Required: `q_valid_o` falls after the drain, and the next grant is ch1 (not ch7).
- Non-power-of-two N=5: with all channels valid, `sel_o` cycles 0,1,2,3,4,0. Random stimulus with seed 123 over 1000 cycles is checked against a reference model for at most one `ready_o` bit set and correct data/sel pairing.
